// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits, stop bit, one bit per clk.
// The assembled word goes out through a single-entry valid/ready output register.
module sipo_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // Consumption first; a load on the same edge overrides it below.
        if (valid_q && dout_ready)
            valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (si) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (MSB_FIRST)
                    sr_d = {sr_q[WIDTH-2:0], si};
                else
                    sr_d = {si, sr_q[WIDTH-1:1]};
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Stop bit of 1 is a framing error and never doubles as a start bit.
                state_d = IDLE;
                if (si) begin
                    ferr_d = 1'b1;
                end else if (!valid_q || dout_ready) begin
                    dout_d  = sr_q;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;
endmodule
